// File: rtl/instr_encoder_if.sv
// Field-bundle and IMEM write bus between the program loader and its driver.
// Latency: none, this is a pure signal bundle.
// Backpressure: in_valid/in_ready handshake on the bundle side; the IMEM write side has no stall.
// Ports: in_valid/in_ready plus in_op/in_rs/in_rt/in_rd/in_funct/in_imm toward the encoder,
//        and mem_we/mem_addr/mem_wdata toward instruction memory.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [2:0]        in_rs;
    logic [2:0]        in_rt;
    logic [2:0]        in_rd;
    logic [2:0]        in_funct;
    logic [13:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_wdata;

    // Driver side: presents field bundles and observes the IMEM writes.
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: packs instruction field bundles into 24-bit words and writes them to IMEM in sequence.
// Latency: bundle accepted in cycle N, IMEM write strobe in cycle N+2; at most one bundle per 3 cycles.
// Backpressure: in_ready low outside IDLE, while full, and during a prog_start cycle.
// Ports: clk, reset (sync, active-high), prog_start (restart at address 0), bus (instr_encoder_if.slave),
//        word_count (words written since start), full (word_count == DEPTH), err_illegal (sticky drop flag).
// Option: defining ENC_CHECKSUM_EN adds output checksum[23:0], the XOR of all words written since start/reset.
module instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_start,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [23:0]       checksum
`endif
);

    localparam logic [3:0] OP_R    = 4'b0110;
    localparam logic [3:0] OP_LS   = 4'b0010;
    localparam logic [3:0] OP_SS   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Registered copy of the accepted bundle.
    logic [3:0]        op_q;
    logic [2:0]        rs_q;
    logic [2:0]        rt_q;
    logic [2:0]        rd_q;
    logic [2:0]        funct_q;
    logic [13:0]       imm_q;

    logic [ADDR_W-1:0] wr_ptr;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       wdata_q;

    logic              ready;
    logic              accept;
    logic              restart;
    logic              drop;
    logic              commit;
    logic              legal;
    logic [23:0]       packed_word;

    always_comb begin
        legal = 1'b0;
        case (op_q)
            OP_R, OP_LS, OP_SS, OP_BEQ, OP_ADDI: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        // Only the fields belonging to the format are packed, so junk on the others cannot leak.
        if (op_q == OP_R) begin
            packed_word = {op_q, rs_q, rt_q, rd_q, funct_q, 8'h00};
        end else begin
            packed_word = {op_q, rs_q, rt_q, imm_q};
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        restart   = 1'b0;
        drop      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                // A restart takes priority: a bundle presented alongside prog_start is not taken.
                ready   = !full && !prog_start;
                restart = prog_start;
                accept  = bus.in_valid && ready;
                if (accept) begin
                    state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                if (legal) begin
                    state_nxt = WRITE;
                end else begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            imm_q       <= '0;
            wr_ptr      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_count  <= '0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
`ifdef ENC_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            state <= state_nxt;
            we_q  <= 1'b0;
            if (accept) begin
                op_q    <= bus.in_op;
                rs_q    <= bus.in_rs;
                rt_q    <= bus.in_rt;
                rd_q    <= bus.in_rd;
                funct_q <= bus.in_funct;
                imm_q   <= bus.in_imm;
            end
            // Address/data are loaded at the end of ENCODE so they are valid for the whole WRITE cycle
            // and then simply hold until the next legal word.
            if (state == ENCODE && legal) begin
                we_q    <= 1'b1;
                addr_q  <= wr_ptr;
                wdata_q <= packed_word;
            end
            if (drop) begin
                err_illegal <= 1'b1;
            end
            if (commit) begin
                wr_ptr     <= wr_ptr + 1'b1;
                word_count <= word_count + 1'b1;
                full       <= ((word_count + 1'b1) == (ADDR_W + 1)'(DEPTH));
`ifdef ENC_CHECKSUM_EN
                checksum   <= checksum ^ wdata_q;
`endif
            end
            if (restart) begin
                wr_ptr      <= '0;
                word_count  <= '0;
                full        <= 1'b0;
                err_illegal <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                checksum    <= '0;
`endif
            end
        end
    end

    // Strobe is masked by reset so a reset landing in the WRITE cycle suppresses that write.
    assign bus.mem_we    = we_q && !reset;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.in_ready  = ready;

endmodule
